std_sram_sp_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the standard single-port SRAM (combinational read, synchronous write). It grants at most one access per cycle to the shared SRAM port. Read data is registered and returned to the owning requester exactly one cycle after grant. It sits between two clients (e.g. fetch and load/store) and one SRAM macro instance.

---
 rtl/std_sram_sp_arbiter.sv | 122 ++++++++++++
 tb/tb_std_sram_sp_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/std_sram_sp_arbiter.sv
// Two-requester round-robin arbiter sequencing one combinational-read / synchronous-write SRAM port.
// Define STD_SRAM_ARB_INIT_CLEAR_EN to zero the whole SRAM after reset before any request is served.
module std_sram_sp_arbiter #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_we,
    input  logic [DATA_WIDTH-1:0] req0_din,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_dout,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_we,
    input  logic [DATA_WIDTH-1:0] req1_din,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_dout,
    output logic                  sram_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_we,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  init_done,
    output logic [1:0]            dbg_state
);

    // Handshake: a request transfers on a cycle where reqN_valid && reqN_ready.
    // Ready is a combinational function of both valids, the state and last_grant;
    // valid never depends on ready, and a requester holds addr/we/din stable until accepted.

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t state;
    logic   last_grant;
    logic   run;
    logic   grant0;
    logic   grant1;

    assign run    = (state == ST_RUN);
    // last_grant==1 means port 1 went last, so port 0 wins the next contention.
    assign grant0 = run & req0_valid & (~req1_valid | last_grant);
    assign grant1 = run & req1_valid & (~req0_valid | ~last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign dbg_state  = {run, last_grant};

`ifdef STD_SRAM_ARB_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0] init_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_INIT;
            init_addr <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            init_addr <= init_addr + 1'b1;
            if (init_addr == {ADDR_WIDTH{1'b1}}) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end
    end
`else
    assign state     = ST_RUN;
    assign init_done = 1'b1;
`endif

    always_comb begin
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        if (grant0) begin
            sram_en   = 1'b1;
            sram_we   = req0_we;
            sram_addr = req0_addr;
            sram_din  = req0_din;
        end else if (grant1) begin
            sram_en   = 1'b1;
            sram_we   = req1_we;
            sram_addr = req1_addr;
            sram_din  = req1_din;
        end
`ifdef STD_SRAM_ARB_INIT_CLEAR_EN
        if (!run) begin
            sram_en   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = init_addr;
            sram_din  = '0;
        end
`endif
    end

    // Read data is captured at the grant edge; dout holds until that port's next read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_dout  <= '0;
            resp1_dout  <= '0;
            last_grant  <= 1'b1;
        end else begin
            resp0_valid <= grant0 & ~req0_we;
            resp1_valid <= grant1 & ~req1_we;
            if (grant0 & ~req0_we)
                resp0_dout <= sram_dout;
            if (grant1 & ~req1_we)
                resp1_dout <= sram_dout;
            if (grant0)
                last_grant <= 1'b0;
            else if (grant1)
                last_grant <= 1'b1;
        end
    end

endmodule

// File: tb/tb_std_sram_sp_arbiter.sv
// Bench for std_sram_sp_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_std_sram_sp_arbiter;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_din;
  logic          resp0_valid;
  logic [DW-1:0] resp0_dout;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_din;
  logic          resp1_valid;
  logic [DW-1:0] resp1_dout;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
  logic          init_done;
  logic [1:0]    dbg_state;

  // SRAM macro stand-in and the reference model's own view of memory
  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] last0, last1;
  int            favour;
  int            wait0, wait1;
  int            n_checks, n_errors;
  bit            mg0, mg1;

  bit            rv0, rv1, rw0, rw1;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;

`ifdef STD_SRAM_ARB_INIT_CLEAR_EN
  localparam bit RUN_AT_RESET = 1'b0;
`else
  localparam bit RUN_AT_RESET = 1'b1;
`endif

  std_sram_sp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_we(req0_we), .req0_din(req0_din),
    .resp0_valid(resp0_valid), .resp0_dout(resp0_dout),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_din(req1_din),
    .resp1_valid(resp1_valid), .resp1_dout(resp1_dout),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_we(sram_we), .sram_dout(sram_dout),
    .init_done(init_done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  always @(posedge clk) if (sram_en && sram_we) sram_mem[sram_addr] <= sram_din;
  assign sram_dout = sram_mem[sram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    last0  = '0;
    last1  = '0;
    favour = 0;
    wait0  = 0;
    wait1  = 0;
  endtask

  task automatic drive_idle();
    req0_valid = 0; req0_addr = '0; req0_we = 0; req0_din = '0;
    req1_valid = 0; req1_addr = '0; req1_we = 0; req1_din = '0;
  endtask

  // Called right at the negedge where resetn is released.
  task automatic post_reset();
`ifdef STD_SRAM_ARB_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("init_en", sram_en, 1);
      check("init_we", sram_we, 1);
      check("init_addr", sram_addr, i);
      check("init_din", sram_din, 0);
      check("init_rdy0", req0_ready, 0);
      check("init_rdy1", req1_ready, 0);
      check("init_done_low", init_done, 0);
    end
    @(negedge clk); #1;
    check("init_done", init_done, 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    #1;
    check("init_done", init_done, 1);
`endif
  endtask

  // One clock of traffic: drive, check last cycle's responses, check this cycle's grant.
  task automatic step(input bit v0, input logic [AW-1:0] a0, input bit w0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input bit w1, input logic [DW-1:0] d1);
    bit g0, g1;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_we = w0; req0_din = d0;
    req1_valid = v1; req1_addr = a1; req1_we = w1; req1_din = d1;
    #1;
    check("resp0_valid", resp0_valid, exp_q0.size() != 0);
    if (exp_q0.size() != 0) last0 = exp_q0.pop_front();
    check("resp0_dout", resp0_dout, last0);
    check("resp1_valid", resp1_valid, exp_q1.size() != 0);
    if (exp_q1.size() != 0) last1 = exp_q1.pop_front();
    check("resp1_dout", resp1_dout, last1);

    g0 = v0 && (!v1 || favour == 0);
    g1 = v1 && !g0;
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    check("sram_en", sram_en, g0 || g1);
    check("sram_we", sram_we, (g0 && w0) || (g1 && w1));
    if (g0 || g1) check("sram_addr", sram_addr, g0 ? a0 : a1);
    if ((g0 && w0) || (g1 && w1)) check("sram_din", sram_din, g0 ? d0 : d1);

    wait0 = (v0 && !req0_ready) ? wait0 + 1 : 0;
    wait1 = (v1 && !req1_ready) ? wait1 + 1 : 0;
    if (v0) check("no_starve0", wait0 < 2, 1);
    if (v1) check("no_starve1", wait1 < 2, 1);

    if (g0) begin
      if (w0) ref_mem[a0] = d0; else exp_q0.push_back(ref_mem[a0]);
      favour = 1;
    end
    if (g1) begin
      if (w1) ref_mem[a1] = d1; else exp_q1.push_back(ref_mem[a1]);
      favour = 0;
    end
    mg0 = g0;
    mg1 = g1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive_idle();
    resetn = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = DW'($urandom);
      ref_mem[i]  = sram_mem[i];
    end
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp1_valid", resp1_valid, 0);
    check("rst_resp0_dout", resp0_dout, 0);
    check("rst_resp1_dout", resp1_dout, 0);
    check("rst_last_grant", dbg_state[0], 1);
    check("rst_run", dbg_state[1], RUN_AT_RESET);
    check("rst_init_done", init_done, RUN_AT_RESET);
    @(negedge clk);
    resetn = 1'b1;
    post_reset();

    // port 1 writes 0xA5 to addr 3, then a lone port 0 read of addr 3
    step(0, 0, 0, 0, 1, 3, 1, 8'hA5);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("a5_readback", resp0_dout, 8'hA5);

    // write 0x3C to addr 5 by port 1, read it back on port 0 the next cycle
    step(0, 0, 0, 0, 1, 5, 1, 8'h3C);
    step(1, 5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("raw_3c", resp0_dout, 8'h3C);

    // both requesters held valid for several cycles
    for (int i = 0; i < 4; i++) step(1, 6, 0, 0, 1, 7, 0, 0);

    // port 0 read and port 1 write of the same address in one cycle
    step(1, 2, 0, 0, 1, 2, 1, 8'h5A);
    step(1, 2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // reset asserted while a port 1 response is on the outputs
    step(0, 0, 0, 0, 1, 4, 0, 0);
    @(posedge clk); #2;
    check("pre_rst_resp1_valid", resp1_valid, 1);
    drive_idle();
    resetn = 1'b0;
    #1;
    check("mid_rst_resp1_valid", resp1_valid, 0);
    check("mid_rst_resp1_dout", resp1_dout, 0);
    check("mid_rst_last_grant", dbg_state[0], 1);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    post_reset();

    // continuous reads from both ports: first contention goes to port 0, then alternate
    step(1, 1, 0, 0, 1, 2, 0, 0);
    check("first_grant_port0", req0_ready, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 1, 2, 0, 0);

    // randomized traffic on a small address space to force collisions
    rv0 = 0;
    rv1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!rv0 && $urandom_range(0, 9) < 7) begin
        rv0 = 1; ra0 = AW'($urandom_range(0, DEPTH - 1)); rw0 = 1'($urandom_range(0, 1)); rd0 = DW'($urandom);
      end
      if (!rv1 && $urandom_range(0, 9) < 7) begin
        rv1 = 1; ra1 = AW'($urandom_range(0, DEPTH - 1)); rw1 = 1'($urandom_range(0, 1)); rd1 = DW'($urandom);
      end
      step(rv0, ra0, rw0, rd0, rv1, ra1, rw1, rd1);
      if (mg0) rv0 = 0;
      if (mg1) rv1 = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
